// File: rtl/fetch.sv
// RV32i instruction fetch stage: owns the PC, drives a synchronous IMEM and
// produces the IF/ID pipeline register, with stall/flush/redirect/fault handling.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall_F,
  input  logic        Flush_D,
  input  logic        PC_Src_Sel,
  input  logic [31:0] Branch_Target_E,
  output logic [31:0] IMEM_Addr,
  input  logic [31:0] IMEM_Data,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC_Plus_4_D,
  output logic        Valid_D,
  output logic        Fetch_Fault,
  output logic [31:0] Fault_Addr
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus_4_d;
  logic        r_valid_d;
  logic        r_fault;
  logic [31:0] r_fault_addr;

  logic [31:0] w_pc_plus_4;
  logic        w_target_ok;
  logic [31:0] w_pc_next;

  assign w_pc_plus_4 = r_pc_f + 32'd4;
  assign w_target_ok = (Branch_Target_E[1:0] == 2'b00);

  // Next-PC select; IMEM latches this same value on the edge PC_F loads it.
  always_comb begin
    w_pc_next = w_pc_plus_4;
    if (RST) begin
      w_pc_next = RESET_PC;
    end else if (r_state != S_RUN) begin
      w_pc_next = r_pc_f;
    end else if (PC_Src_Sel) begin
      w_pc_next = w_target_ok ? Branch_Target_E : r_pc_f;
    end else if (Stall_F) begin
      w_pc_next = r_pc_f;
    end
  end

  assign IMEM_Addr = w_pc_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_BOOT;
      r_pc_f        <= RESET_PC;
      r_instr_d     <= NOP_INSTR;
      r_pc_d        <= 32'd0;
      r_pc_plus_4_d <= 32'd0;
      r_valid_d     <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_addr  <= 32'd0;
    end else begin
      r_pc_f <= w_pc_next;
      case (r_state)
        S_BOOT: begin
          r_state       <= S_RUN;
          r_instr_d     <= NOP_INSTR;
          r_pc_d        <= 32'd0;
          r_pc_plus_4_d <= 32'd0;
          r_valid_d     <= 1'b0;
        end
        S_RUN: begin
          if (PC_Src_Sel) begin
            // F-stage instruction is wrong-path; a misaligned target halts fetch.
            r_instr_d     <= NOP_INSTR;
            r_pc_d        <= 32'd0;
            r_pc_plus_4_d <= 32'd0;
            r_valid_d     <= 1'b0;
            if (!w_target_ok) begin
              r_state      <= S_HALT;
              r_fault      <= 1'b1;
              r_fault_addr <= Branch_Target_E;
            end
          end else if (Flush_D) begin
            r_instr_d     <= NOP_INSTR;
            r_pc_d        <= 32'd0;
            r_pc_plus_4_d <= 32'd0;
            r_valid_d     <= 1'b0;
          end else if (!Stall_F) begin
            r_instr_d     <= IMEM_Data;
            r_pc_d        <= r_pc_f;
            r_pc_plus_4_d <= w_pc_plus_4;
            r_valid_d     <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_HALT;
          r_instr_d     <= NOP_INSTR;
          r_pc_d        <= 32'd0;
          r_pc_plus_4_d <= 32'd0;
          r_valid_d     <= 1'b0;
        end
      endcase
    end
  end

  assign Instr_D     = r_instr_d;
  assign PC_D        = r_pc_d;
  assign PC_Plus_4_D = r_pc_plus_4_d;
  assign Valid_D     = r_valid_d;
  assign Fetch_Fault = r_fault;
  assign Fault_Addr  = r_fault_addr;

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage of the RV32i pipeline, directly upstream of `decode`. It owns the program counter and drives a synchronous instruction memory. It also owns the IF/ID pipeline register that produces `Instr_D`, `PC_D` and `PC_Plus_4_D` for decode. It handles hazard-unit stalls and flushes, execute-stage redirects (branch/jump), and misaligned-target faults.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`) inserted into IF/ID.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset; synchronous and active-high.
- `Stall_F`  in  1  hazard unit: hold PC and IF/ID.
- `Flush_D`  in  1  hazard unit: load bubble into IF/ID.
- `PC_Src_Sel`  in  1  execute: redirect taken; next PC = `Branch_Target_E`.
- `Branch_Target_E`  in  32  redirect target from execute.
- `IMEM_Addr`  out  32  combinational address to instruction memory. Memory registers it on the rising edge.
- `IMEM_Data`  in  32  memory read data, valid the cycle after the address is latched.
- `Instr_D`  out  32  IF/ID instruction.
- `PC_D`  out  32  IF/ID PC.
- `PC_Plus_4_D`  out  32  IF/ID PC+4.
- `Valid_D`  out  1  IF/ID holds a real instruction (0 = bubble).
- `Fetch_Fault`  out  1  sticky misaligned-target fault.
- `Fault_Addr`  out  32  offending target captured on fault.

## Operation
- State machine states:
  - `S_BOOT`: entered on reset.
  - `S_RUN`: normal fetch.
  - `S_HALT`: faulted. Left only by `RST`.
- Registers: `PC_F`, state, IF/ID (`Instr_D`, `PC_D`, `PC_Plus_4_D`, `Valid_D`), `Fetch_Fault`, `Fault_Addr`.
- `IMEM_Addr` is always equal to `PC_Next`. Memory therefore latches `PC_Next` at the same edge that `PC_F <= PC_Next`. During the following cycle, `IMEM_Data = mem[PC_F]`.
- `PC_Next` selection (first match wins):
  1. `RST` → `RESET_PC`.
  2. `S_BOOT` or `S_HALT` → `PC_F`.
  3. `PC_Src_Sel` with `Branch_Target_E[1:0]==0` → `Branch_Target_E`.
  4. `PC_Src_Sel` with misaligned target → `PC_F`.
  5. `Stall_F` → `PC_F`.
  6. Otherwise → `PC_F + 4`.
- Arithmetic: PC+4 is computed modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000. No other width extension.
- IF/ID update (first match wins):
  1. `RST` → `NOP_INSTR`/0/0/0.
  2. `S_BOOT` or `S_HALT` → bubble.
  3. `PC_Src_Sel` → bubble. The F-stage instruction is wrong-path.
  4. `Flush_D` → bubble.
  5. `Stall_F` → hold.
  6. Otherwise → `Instr_D=IMEM_Data`, `PC_D=PC_F`, `PC_Plus_4_D=PC_F+4`, `Valid_D=1`.
- Bubble means `Instr_D=NOP_INSTR`, `PC_D=0`, `PC_Plus_4_D=0`, `Valid_D=0`.
- Transitions:
  - `S_BOOT` → `S_RUN` unconditionally after one cycle.
  - `S_RUN` → `S_HALT` when `PC_Src_Sel` is set with `Branch_Target_E[1:0]!=0`. On that edge, set `Fetch_Fault=1` and `Fault_Addr=Branch_Target_E`.
  - `S_HALT` persists; `Stall_F`, `Flush_D` and `PC_Src_Sel` are ignored.
- Simultaneous events:
  - Redirect beats stall and flush.
  - Flush beats stall for IF/ID. The PC still holds if `Stall_F`.
- Stall keeps `IMEM_Addr` equal to `PC_F`, so `IMEM_Data` stays stable with no skid buffer.

## Timing
- Reset values:
  - `PC_F=RESET_PC`, state `S_BOOT`.
  - `Instr_D=NOP_INSTR`, `PC_D=0`, `PC_Plus_4_D=0`, `Valid_D=0`.
  - `Fetch_Fault=0`, `Fault_Addr=0`.
  - `IMEM_Addr=RESET_PC` while `RST` is high.
- `RST` asserted mid-operation overrides everything on that edge, including an in-progress redirect or halt.
- First valid `Instr_D` appears on the 2nd rising edge after `RST` deasserts. The 1st edge is the `S_BOOT` bubble.
- Steady state: one instruction per cycle. Fetch-to-decode latency is 1 edge from `PC_F` to `PC_D`.
- Redirect sampled at edge N:
  - Bubble in IF/ID after edge N.
  - `mem[target]` reaches `Instr_D` at edge N+1.
  - Penalty is 1 cycle in F. The D-stage kill is the hazard unit's job via `Flush_D`.
- A stall held for k cycles freezes all IF/ID outputs for k edges. Fetch resumes with the held PC.
- `Fetch_Fault` rises at the redirect edge and remains high until reset.

## Test plan
- Reset: hold `RST` for 3 cycles, release, memory holds `mem[i]=i` → bubble at edge 1; at edge 2 `Instr_D=0`, `PC_D=0`, `PC_Plus_4_D=4`, `Valid_D=1`; at edge 3 `PC_D=4`.
- Stall: assert `Stall_F` for 2 cycles while `PC_D=8` → IF/ID holds `PC_D=8` for both edges; after release `PC_D=12`, with no skipped or duplicated instruction.
- Redirect: `PC_Src_Sel=1`, `Branch_Target_E=32'h40` while `PC_F=32'h10` → next edge gives bubble (`Valid_D=0`); following edge gives `PC_D=32'h40`, `Instr_D=mem[32'h40]`.
- Simultaneous events: `Stall_F`, `Flush_D` and a redirect to 32'h80 on the same edge → redirect wins (bubble, then `PC_D=32'h80`); separately, `Flush_D` with `Stall_F` → bubble and PC held.
- Fault: redirect to 32'h0000_0102 → `Fetch_Fault=1` and `Fault_Addr=32'h102` at that edge; `Valid_D` stays 0 for 10 cycles despite further redirects; `RST` clears the fault.
- Wrap: with `RESET_PC=32'hFFFF_FFF8` → sequential `PC_D` values `FFFF_FFF8`, `FFFF_FFFC`, `0000_0000`, and `PC_Plus_4_D=0` for the `FFFF_FFFC` entry.
